// File: rtl/rg_pkg.sv
// Shared definitions for the rg_mdx configurable register:
// bit-class encodings, default mask constants, class selection.
package rg_pkg;

  typedef enum logic [1:0] {
    CLS_PLAIN  = 2'd0,
    CLS_W1C    = 2'd1,
    CLS_BUF    = 2'd2,
    CLS_UNIMPL = 2'd3
  } rg_class_e;

  localparam int RG_MAX_W = 32;

  localparam logic [RG_MAX_W-1:0] RG_INIT_DEF = '0;
  localparam logic [RG_MAX_W-1:0] RG_IMPL_DEF = '1;
  localparam logic [RG_MAX_W-1:0] RG_W1C_DEF  = '0;
  localparam logic [RG_MAX_W-1:0] RG_BUF_DEF  = '0;

  // Flag wins over buffering when a bit sits in both masks.
  function automatic rg_class_e rg_class(
    input logic impl,
    input logic w1c,
    input logic bf
  );
    if (!impl)    return CLS_UNIMPL;
    else if (w1c) return CLS_W1C;
    else if (bf)  return CLS_BUF;
    else          return CLS_PLAIN;
  endfunction

endpackage

// File: rtl/rg_mdx_bit.sv
// One register bit; class fixed at elaboration.
// Unimplemented bits are constants and hold no flops.
module rg_mdx_bit
  import rg_pkg::*;
#(
  parameter rg_class_e p_class = CLS_PLAIN,
  parameter logic      p_init  = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic wd,
  input  logic wbe,
  input  logic tog,
  input  logic hw_set,
  input  logic commit,
  output logic act,
  output logic buf_q
);

  // Toggle beats load where wd=1; wd=0 under toggle alone keeps the bit.
  function automatic logic ld_next(input logic q);
    if (tog && wd) return ~q;
    else if (wbe)  return wd;
    else           return q;
  endfunction

  logic unused_in;
  assign unused_in = &{1'b0, clk, nrst, wd, wbe, tog, hw_set, commit};

  if (p_class == CLS_UNIMPL) begin : g_unimpl
    assign act   = p_init;
    assign buf_q = p_init;
  end else if (p_class == CLS_PLAIN) begin : g_plain
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) act <= p_init;
      else       act <= ld_next(act);
    end
    assign buf_q = act;
  end else if (p_class == CLS_W1C) begin : g_w1c
    // Set dominates clear so a coincident event is not lost.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)            act <= p_init;
      else if (hw_set)      act <= 1'b1;
      else if (wbe && wd)   act <= 1'b0;
    end
    assign buf_q = act;
  end else begin : g_buf
    logic b_q;
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        b_q <= p_init;
        act <= p_init;
      end else begin
        b_q <= ld_next(b_q);
        if (commit) act <= b_q;
      end
    end
    assign buf_q = b_q;
  end

endmodule

// File: rtl/rg_mdx.sv
// Configurable control/status register with plain, flag,
// double-buffered and unimplemented bits; pend and irq here.
module rg_mdx
  import rg_pkg::*;
#(
  parameter int                 p_width     = 8,
  parameter logic [p_width-1:0] p_init_val  = RG_INIT_DEF[p_width-1:0],
  parameter logic [p_width-1:0] p_impl_mask = RG_IMPL_DEF[p_width-1:0],
  parameter logic [p_width-1:0] p_w1c_mask  = RG_W1C_DEF[p_width-1:0],
  parameter logic [p_width-1:0] p_buf_mask  = RG_BUF_DEF[p_width-1:0]
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [p_width-1:0] wdata,
  input  logic               wbe,
  input  logic               tog,
  input  logic [p_width-1:0] hw_set,
  input  logic               upd,
  input  logic [p_width-1:0] ie,
  output logic [p_width-1:0] rdata,
  output logic [p_width-1:0] bdata,
  output logic               pend,
  output logic               irq
);

  localparam logic has_buf = |(p_buf_mask & p_impl_mask);

  logic commit;
  assign commit = upd & pend;

  for (genvar i = 0; i < p_width; i++) begin : g_bit
    localparam rg_class_e cls =
      rg_class(p_impl_mask[i], p_w1c_mask[i], p_buf_mask[i]);
    rg_mdx_bit #(
      .p_class (cls),
      .p_init  (p_init_val[i])
    ) u_bit (
      .clk    (clk),
      .nrst   (nrst),
      .wd     (wdata[i]),
      .wbe    (wbe),
      .tog    (tog),
      .hw_set (hw_set[i]),
      .commit (commit),
      .act    (rdata[i]),
      .buf_q  (bdata[i])
    );
  end

  // A write in the commit cycle re-arms pend for the new buffer value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                    pend <= 1'b0;
    else if (has_buf && (wbe || tog)) pend <= 1'b1;
    else if (upd)                 pend <= 1'b0;
  end

  assign irq = |(rdata & p_w1c_mask & ie);

endmodule

// File: tb/tb_rg_mdx.sv
// Directed table-driven bench for rg_mdx with
// impl=7F, w1c=30, buf=0C, init=00.
module tb_rg_mdx;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] wdata = '0;
  logic       wbe = 1'b0;
  logic       tog = 1'b0;
  logic [7:0] hw_set = '0;
  logic       upd = 1'b0;
  logic [7:0] ie = '0;
  logic [7:0] rdata;
  logic [7:0] bdata;
  logic       pend;
  logic       irq;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rg_mdx #(
    .p_width     (8),
    .p_init_val  (8'h00),
    .p_impl_mask (8'h7F),
    .p_w1c_mask  (8'h30),
    .p_buf_mask  (8'h0C)
  ) dut (
    .clk    (clk),
    .nrst   (nrst),
    .wdata  (wdata),
    .wbe    (wbe),
    .tog    (tog),
    .hw_set (hw_set),
    .upd    (upd),
    .ie     (ie),
    .rdata  (rdata),
    .bdata  (bdata),
    .pend   (pend),
    .irq    (irq)
  );

  typedef struct {
    string      name;
    logic [7:0] wd;
    logic       wbe;
    logic       tog;
    logic [7:0] hw;
    logic       upd;
    logic [7:0] ie;
    logic [7:0] r;
    logic [7:0] b;
    logic       p;
    logic       i;
  } vec_t;

  vec_t v[16];

  task automatic check(input string nm, input logic [7:0] er,
                       input logic [7:0] eb, input logic ep,
                       input logic ei);
    n_run++;
    if (rdata !== er || bdata !== eb || pend !== ep || irq !== ei) begin
      n_fail++;
      $display("FAIL %s: got r=%h b=%h p=%b i=%b want r=%h b=%h p=%b i=%b",
               nm, rdata, bdata, pend, irq, er, eb, ep, ei);
    end
  endtask

  task automatic drive(input vec_t x);
    wdata  = x.wd;
    wbe    = x.wbe;
    tog    = x.tog;
    hw_set = x.hw;
    upd    = x.upd;
    ie     = x.ie;
  endtask

  initial begin
    //        name       wd     wbe   tog   hw     upd   ie     r      b      p     i
    v[0]  = '{"wr_ff",   8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h43, 8'h4F, 1'b1, 1'b0};
    v[1]  = '{"idle",    8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h43, 8'h4F, 1'b1, 1'b0};
    v[2]  = '{"upd1",    8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h4F, 8'h4F, 1'b0, 1'b0};
    v[3]  = '{"upd2",    8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h4F, 8'h4F, 1'b0, 1'b0};
    v[4]  = '{"tog41",   8'h41, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h0E, 8'h0E, 1'b1, 1'b0};
    v[5]  = '{"tog04",   8'h04, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h0E, 8'h0A, 1'b1, 1'b0};
    v[6]  = '{"upd_tog", 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h0A, 8'h0A, 1'b0, 1'b0};
    v[7]  = '{"wr04",    8'h04, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h08, 8'h04, 1'b1, 1'b0};
    v[8]  = '{"upd_wr08",8'h08, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h04, 8'h08, 1'b1, 1'b0};
    v[9]  = '{"hwset4",  8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 8'h10, 8'h14, 8'h18, 1'b1, 1'b1};
    v[10] = '{"set_clr", 8'h10, 1'b1, 1'b0, 8'h10, 1'b0, 8'h10, 8'h14, 8'h10, 1'b1, 1'b1};
    v[11] = '{"clr4",    8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 8'h10, 8'h04, 8'h00, 1'b1, 1'b0};
    v[12] = '{"hw_misc", 8'h00, 1'b0, 1'b0, 8'hA1, 1'b0, 8'hFF, 8'h24, 8'h20, 1'b1, 1'b1};
    v[13] = '{"tog_flg", 8'h30, 1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 8'h24, 8'h20, 1'b1, 1'b1};
    v[14] = '{"wr_b7",   8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h24, 8'h20, 1'b1, 1'b1};
    v[15] = '{"tog_pri", 8'h41, 1'b1, 1'b1, 8'h00, 1'b0, 8'hFF, 8'h65, 8'h61, 1'b1, 1'b1};

    #1;
    check("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    nrst = 1'b1;

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      drive(v[k]);
      @(posedge clk);
      #1;
      check(v[k].name, v[k].r, v[k].b, v[k].p, v[k].i);
    end

    // Reset mid-pending: must clear without a clock edge.
    @(negedge clk);
    wdata = '0; wbe = 0; tog = 0; hw_set = '0; upd = 0; ie = 8'hFF;
    #2;
    nrst = 1'b0;
    #1;
    check("async_rst", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    nrst = 1'b1;

    // Buffer contents were discarded: upd with pend=0 changes nothing.
    upd = 1'b1;
    @(posedge clk);
    #1;
    check("upd_after_rst", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    upd = 1'b0;

    // Flag set again after reset raises irq combinationally from flop.
    hw_set = 8'h20;
    @(posedge clk);
    #1;
    check("irq_after_rst", 8'h20, 8'h20, 1'b0, 1'b1);
    @(negedge clk);
    hw_set = '0;
    ie = 8'h10;
    #1;
    check("ie_mask", 8'h20, 8'h20, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/rg_mdx.md
RG_MDX -- requirements
Module: rg_mdx

Interface
REQ-001 SHALL have parameter p_width, default 8: register width in bits, 1..32.
REQ-002 SHALL have parameter p_init_val, default all 0: reset value per bit.
REQ-003 SHALL have parameter p_impl_mask, default all 1: 1 = bit implemented.
REQ-004 SHALL have parameter p_w1c_mask, default all 0: 1 = flag bit (hardware-set, write-one-to-clear).
REQ-005 SHALL have parameter p_buf_mask, default all 0: 1 = double-buffered bit (write to buffer, commit on upd).
REQ-006 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-007 SHALL have port nrst  input  1  asynchronous active-low reset.
REQ-008 SHALL have port wdata  input  p_width  CPU write data.
REQ-009 SHALL have port wbe  input  1  CPU write strobe, one cycle per access.
REQ-010 SHALL have port tog  input  1  toggle strobe; bits with wdata[i]=1 invert.
REQ-011 SHALL have port hw_set  input  p_width  hardware set request for flag bits.
REQ-012 SHALL have port upd  input  1  commit strobe for buffered bits.
REQ-013 SHALL have port ie  input  p_width  per-bit interrupt enable for flag bits.
REQ-014 SHALL have port rdata  output  p_width  active register value.
REQ-015 SHALL have port bdata  output  p_width  buffer value; non-buffered bits read as the active value.
REQ-016 SHALL have port pend  output  1  buffered write awaiting commit.
REQ-017 SHALL have port irq  output  1  OR of (active & p_w1c_mask & ie).

Function
REQ-018 Unimplemented bits SHALL read p_init_val permanently, ignore all inputs, and hold no flops.
REQ-019 Plain bits (not w1c, not buf): tog&wdata[i] SHALL invert the bit, else wbe SHALL load wdata[i]; tog has priority over wbe on bits with wdata[i]=1.
REQ-020 Plain bits SHALL change on the clock edge following the strobe; rdata shows the new value one cycle after the strobe.
REQ-021 Flag bits: hw_set[i]=1 SHALL set the bit; wbe with wdata[i]=1 SHALL clear it; wdata[i]=0 SHALL leave it unchanged.
REQ-022 Flag bits: simultaneous hw_set[i] and a clear SHALL leave the bit set, so no event is lost.
REQ-023 Flag bits SHALL ignore tog; hw_set SHALL be ignored on non-flag bits.
REQ-024 Buffered bits: wbe/tog SHALL act on the buffer with the same rules as REQ-019; the active bit is unchanged.
REQ-025 Any wbe or tog cycle SHALL set pend when p_buf_mask&p_impl_mask is non-zero.
REQ-026 upd with pend=1 SHALL copy the buffer to the active buffered bits and clear pend; upd with pend=0 SHALL do nothing.
REQ-027 Simultaneous upd and write SHALL commit the pre-write buffer value, load the new value into the buffer, and leave pend=1.
REQ-028 If a bit is in both masks, p_w1c_mask SHALL take precedence and the bit is treated as unbuffered.
REQ-029 irq SHALL be registered-output combinational on active state, with no added latency beyond the flag flop.

Reset
REQ-030 nrst low SHALL asynchronously force active and buffer to p_init_val and pend to 0.
REQ-031 After reset, irq SHALL equal |(p_init_val & p_w1c_mask & ie).
REQ-032 Reset asserted mid-pending SHALL discard the uncommitted buffer contents.

Structure
REQ-033 A shared package rg_pkg SHALL hold the bit-class encodings (plain, w1c, buf, unimpl) and the default mask constants.
REQ-034 A per-bit cell rg_mdx_bit SHALL implement one bit for all classes and be instantiated by generate over p_width; pend and irq logic live in rg_mdx.

Verification (p_width=8, p_init_val=8'h00, p_impl_mask=8'h7F, p_w1c_mask=8'h30, p_buf_mask=8'h0C)
REQ-035 wbe, wdata=8'hFF -> next cycle rdata=8'h43, bdata=8'h4F, pend=1; bit7 reads 0; flags stay 0.
REQ-036 upd after REQ-035 -> rdata=8'h4F, pend=0; a second upd causes no change.
REQ-037 hw_set=8'h10, ie=8'h10 -> rdata[4]=1, irq=1; wbe wdata=8'h10 with hw_set=8'h10 in the same cycle -> bit stays 1; wbe wdata=8'h10 alone -> bit 0, irq=0.
REQ-038 From rdata=8'h4F: tog, wdata=8'h41 -> rdata=8'h0E; tog with wdata=8'h04 -> bdata[2]=0, rdata[2] unchanged until upd.
REQ-039 Write 8'h04 (pend=1), then upd together with a write of 8'h08 -> active bits[3:2]=2'b01, bdata[3:2]=2'b10, pend=1.
REQ-040 nrst pulse while pend=1 -> rdata=bdata=8'h00, pend=0, irq=0 without waiting for a clock edge.
